pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 91 +++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Packs valid RGB pixels with their frame coordinates into 44-bit FIFO words.
// Pixels that arrive while the FIFO is full are dropped and counted.
module pixel_packer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk_25,
   input  logic        rst_n,
   input  logic        in_vs,
   input  logic        in_val,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic        wrfull,
   output logic        wrclk,
   output logic        wrreq,
   output logic [43:0] data,
   output logic        frame_done,
   output logic        overflow,
   output logic [15:0] drop_cnt
);

   localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [9:0]  x_cur, y_cur;
   logic        wrreq_q, wrreq_d;
   logic [43:0] data_q, data_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic [15:0] drop_q, drop_d;
   logic        drop_px;

   assign wrclk = clk_25;

   always_comb begin
      // in_vs restarts the frame before the same-cycle pixel is placed
      x_cur   = in_vs ? 10'd0 : x_q;
      y_cur   = in_vs ? 10'd0 : y_q;
      ovf_d   = in_vs ? 1'b0  : ovf_q;
      drop_d  = in_vs ? 16'd0 : drop_q;
      x_d     = x_cur;
      y_d     = y_cur;
      drop_px = in_val & wrfull;
      wrreq_d = in_val & ~wrfull;
      data_d  = wrreq_d ? {x_cur, y_cur, in_r, in_g, in_b} : data_q;
      done_d  = in_val && (x_cur == X_LAST) && (y_cur == Y_LAST);

      if (in_val) begin
         if (x_cur == X_LAST) begin
            x_d = 10'd0;
            y_d = (y_cur == Y_LAST) ? 10'd0 : y_cur + 10'd1;
         end else begin
            x_d = x_cur + 10'd1;
         end
      end

      if (drop_px) begin
         ovf_d = 1'b1;
         if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
      end
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= 10'd0;
         y_q     <= 10'd0;
         wrreq_q <= 1'b0;
         data_q  <= 44'd0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         drop_q  <= 16'd0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         wrreq_q <= wrreq_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign wrreq      = wrreq_q;
   assign data       = data_q;
   assign frame_done = done_q;
   assign overflow   = ovf_q;
   assign drop_cnt   = drop_q;

endmodule
